// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits on one active-low bus.
// Optional digit blinking is built when SEG7_SCAN_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
`ifdef SEG7_SCAN_BLINK_EN
    ,
    parameter int BLINK_DIV   = 25
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic                    lz_blank,
`ifdef SEG7_SCAN_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [CNT_W-1:0]                presc;
    logic [IDX_W-1:0]                idx;
    logic [NUM_DIGITS-1:0][3:0]      shadow;
    logic [NUM_DIGITS-1:0]           dp_shadow;
    logic                            tick;
    logic [NUM_DIGITS-1:0]           blank;
    logic                            zero_run;
    logic                            dark_digit;

    function automatic logic [6:0] hex7(input logic [3:0] n);
        case (n)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            default: hex7 = 7'h0E;
        endcase
    endfunction

    assign tick = en && (presc == CNT_W'(REFRESH_DIV - 1));

    // A digit is blank when it and every more-significant nibble are zero; digit 0 always shows.
    always_comb begin
        zero_run = 1'b1;
        blank    = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (shadow[i] == 4'h0);
            blank[i] = lz_blank && (i > 0) && zero_run;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            if (NUM_DIGITS > 1)
                idx <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else if (en) begin
            presc <= presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            dp_shadow <= '0;
        end else if (load) begin
            shadow    <= value;
            dp_shadow <= dp_in;
        end
    end

`ifdef SEG7_SCAN_BLINK_EN
    localparam int BL_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [BL_W-1:0] blink_cnt;
    logic            blink_phase;

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BL_W'(BLINK_DIV - 1)) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    assign dark_digit = blink_phase && blink_mask[idx];
`else
    assign dark_digit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst || !en) begin
            seg <= 7'h7F;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= (blank[idx] || dark_digit) ? 7'h7F : hex7(shadow[idx]);
            dp  <= dark_digit ? 1'b1 : ~dp_shadow[idx];
        end
    end

endmodule
